// File: rtl/spi_pkg.sv
// spi_pkg: types and constants shared by the SPI master and slave.
// Mode 0 only: sclk idles low, data sampled on the rising edge.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int SPI_DATA_W = 8;
  localparam bit SPI_CPOL   = 1'b0;
  localparam bit SPI_CPHA   = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop pin synchroniser plus history flop.
// rise/fall compare the synchronised value with the history flop.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~hist_q;
  assign fall = ~sync & hist_q;

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI mode-0 slave, MSB first.
// Resyncs the pins into clk, deserialises mosi and serialises a reply on miso.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

  logic unused_sclk_sync, sclk_rise, sclk_fall;
  logic unused_ss_sync, ss_rise, ss_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sync_sclk (
    .clk  (clk),
    .reset(reset),
    .d    (sclk),
    .sync (unused_sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_sync_ss (
    .clk  (clk),
    .reset(reset),
    .d    (ss),
    .sync (unused_ss_sync),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sync_mosi (
    .clk  (clk),
    .reset(reset),
    .d    (mosi),
    .sync (mosi_s),
    .rise (unused_mosi_rise),
    .fall (unused_mosi_fall)
  );

  spi_state_e state_q, state_d;

  logic [CW-1:0]     bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_next;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              full_q, full_d;
  logic              rx_valid_q, underrun_q, frame_err_q;
  logic              load, shift_tx, sample, abort;
  logic              capture, byte_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (ss_fall) state_d = SHIFT;
      SHIFT: if (ss_rise) state_d = IDLE;
    endcase
  end

  // ss edges outrank sclk edges; in IDLE sclk is ignored entirely
  always_comb begin
    load     = 1'b0;
    shift_tx = 1'b0;
    sample   = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE:  load = ss_fall;
      SHIFT: begin
        if (ss_rise) begin
          abort = 1'b1;
        end else if (sclk_rise) begin
          sample = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) shift_tx = 1'b1;
          else                 load     = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    cnt_inc   = bit_cnt_q + CW'(1);
    byte_done = sample && (cnt_inc == CNT_FULL);
    rx_next   = {rx_sh_q[DATA_W-2:0], mosi_s};
    capture   = tx_valid && !full_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    hold_d    = hold_q;
    full_d    = full_q;
    if (abort) bit_cnt_d = '0;
    if (sample) begin
      rx_sh_d   = rx_next;
      bit_cnt_d = byte_done ? '0 : cnt_inc;
    end
    if (byte_done) rx_data_d = rx_next;
    if (shift_tx)  tx_sh_d   = tx_sh_q << 1;
    if (load) begin
      tx_sh_d = full_q ? hold_q : '0;
      full_d  = 1'b0;
    end
    // an accepted handshake always lands, even beside an underrun load
    if (capture) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      full_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      full_q      <= full_d;
      rx_valid_q  <= byte_done;
      underrun_q  <= load && !full_q;
      frame_err_q <= abort && (bit_cnt_q != '0);
    end
  end

  assign busy        = (state_q == SHIFT);
  assign miso        = busy & tx_sh_q[DATA_W-1];
  assign tx_ready    = ~full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: SPI master model, transaction-level scoreboard
// and directed frames for spi_slave_rx.
module tb_spi_slave_rx;

  localparam int W = 8;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         sclk     = 1'b0;
  logic         ss       = 1'b1;
  logic         mosi     = 1'b0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         miso, tx_ready, rx_valid, tx_underrun, frame_err, busy;
  logic [W-1:0] rx_data;

  int n_checks = 0;
  int n_err    = 0;
  int n_und    = 0;
  int n_ferr   = 0;
  int exp_und  = 0;
  int exp_ferr = 0;

  logic         prev_rxv = 1'b0;
  logic [W-1:0] last_rx  = '0;
  logic [W-1:0] exp_rx[$];
  logic [W-1:0] hq[$];
  logic [W-1:0] snd[$];
  logic [W-1:0] got[$];
  logic [W-1:0] rx_log[$];

  spi_slave_rx #(
    .DATA_W     (W),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .ss         (ss),
    .mosi       (mosi),
    .miso       (miso),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_underrun(tx_underrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // every cycle: rx_data must hold the last expected byte,
  // and each rx_valid pulse must deliver the next expected byte
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid) begin
        chk("rx_valid_width", prev_rxv, 0);
        chk("rx_valid_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) begin
          last_rx = exp_rx.pop_front();
          chk("rx_data_new", rx_data, last_rx);
        end
        rx_log.push_back(rx_data);
      end else begin
        chk("rx_data_hold", rx_data, last_rx);
      end
      if (tx_underrun) n_und++;
      if (frame_err)   n_ferr++;
    end
    prev_rxv = rx_valid;
  end

  task automatic model_load(output logic [W-1:0] b);
    if (hq.size() != 0) begin
      b = hq.pop_front();
    end else begin
      b = '0;
      exp_und++;
    end
  endtask

  task automatic model_reset();
    hq.delete();
    exp_rx.delete();
    last_rx = '0;
  endtask

  task automatic push(input logic [W-1:0] b);
    @(negedge clk);
    chk("tx_ready_free", tx_ready, hq.size() == 0);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    hq.push_back(b);
    chk("tx_ready_full", tx_ready, hq.size() == 0);
  endtask

  // master: mode 0, mosi changes with sclk fall, miso sampled late
  task automatic frame(input int nbits, input int half, input int rst_after);
    logic [W-1:0] mb, cur;
    int ph;
    mb = '0;
    ph = $urandom_range(1, 9);
    @(posedge clk);
    #(ph);
    mosi = snd[0][W-1];
    ss   = 1'b0;
    model_load(cur);
    #(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_after) begin
        reset = 1'b0;
        model_reset();
        #1;
        chk("reset_outputs",
            {miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy},
            {1'b0, 1'b1, 8'h00, 4'h0});
        sclk = 1'b0;
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        return;
      end
      sclk = 1'b1;
      if (i % W == W - 1) exp_rx.push_back(snd[i / W]);
      #(half);
      mb = {mb[W-2:0], miso};
      if (i == 0) chk("busy_mid", busy, 1);
      sclk = 1'b0;
      if (i % W == W - 1) begin
        chk("miso_byte", mb, cur);
        got.push_back(mb);
        model_load(cur);
      end
      if (i + 1 < nbits) mosi = snd[(i + 1) / W][W - 1 - ((i + 1) % W)];
      #(half);
    end
    ss   = 1'b1;
    mosi = 1'b0;
    if (nbits % W != 0) exp_ferr++;
  endtask

  task automatic settle(input string nm);
    repeat (10) @(negedge clk);
    chk({nm, "_underruns"}, n_und, exp_und);
    chk({nm, "_frame_errs"}, n_ferr, exp_ferr);
    chk({nm, "_rx_missing"}, exp_rx.size(), 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_miso_idle"}, miso, 0);
    chk({nm, "_tx_ready"}, tx_ready, hq.size() == 0);
  endtask

  initial begin
    int k;
    logic [W-1:0] r, prev;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_values",
        {miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy},
        {1'b0, 1'b1, 8'h00, 4'h0});
    reset = 1'b1;
    repeat (4) @(negedge clk);

    push(8'hA5);
    snd = '{8'h3C};
    got.delete();
    rx_log.delete();
    frame(8, 40, -1);
    settle("single");
    chk("single_rx", rx_data, 8'h3C);
    chk("single_miso", got[0], 8'hA5);
    chk("single_pulses", rx_log.size(), 1);

    push(8'h81);
    snd = '{8'h55, 8'hAA};
    got.delete();
    rx_log.delete();
    fork
      frame(16, 40, -1);
      begin
        repeat (12) @(negedge clk);
        push(8'h7E);
      end
    join
    settle("b2b");
    chk("b2b_rx0", rx_log[0], 8'h55);
    chk("b2b_rx1", rx_log[1], 8'hAA);
    chk("b2b_miso0", got[0], 8'h81);
    chk("b2b_miso1", got[1], 8'h7E);

    k = n_und;
    snd = '{8'hFF};
    got.delete();
    fork
      frame(8, 40, -1);
      begin
        repeat (20) @(negedge clk);
        push(8'h5A);
      end
    join
    settle("underrun");
    chk("und_pulses", n_und - k, 1);
    chk("und_miso", got[0], 8'h00);
    chk("und_rx", rx_data, 8'hFF);

    k = n_ferr;
    snd = '{8'h0F};
    rx_log.delete();
    frame(5, 40, -1);
    settle("abort");
    chk("abort_ferr", n_ferr - k, 1);
    chk("abort_no_rx", rx_log.size(), 0);
    chk("abort_rx_kept", rx_data, 8'hFF);

    snd = '{8'hE7};
    fork
      frame(8, 40, 3);
      begin
        repeat (12) @(negedge clk);
        push(8'h44);
      end
    join
    settle("rst");
    push(8'h69);
    snd = '{8'h96};
    got.delete();
    rx_log.delete();
    frame(8, 40, -1);
    settle("post_rst");
    chk("post_rst_rx", rx_data, 8'h96);
    chk("post_rst_miso", got[0], 8'h69);

    prev = 8'hC3;
    for (int n = 0; n < 256; n++) begin
      r = 8'($urandom_range(0, 255));
      push(prev);
      snd.delete();
      snd.push_back(r);
      frame(8, 20, -1);
      repeat (6) @(negedge clk);
      prev = r;
    end
    settle("stress");
    chk("stress_last_rx", rx_data, prev);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
